wb_buffer_param: RTL
====================

Name: wb_buffer_param

Overview:
- Parametrised write-back store buffer; next generation of the fixed 4-entry WB buffer between the WB pipeline latch and cache/mem.
- Circular FIFO of DEPTH store entries: enqueue from the pipeline, commit by instruction EIP, and in-order drain from the head to memory.
- New versus the 4-entry buffer:
  - depth and field widths are parameters;
  - commit uses a dedicated port;
  - flush discards uncommitted (speculative) entries;
  - loads can look up the buffer and get forwarded data;
  - buffer exposes occupancy and overflow status.

Parameters:
DEPTH, 8, number of entries; power of two, 2..32
AW, 15, address width
DW, 32, data width
EW, 32, EIP width
PW, 3 (log2 DEPTH), pointer width; must equal log2(DEPTH)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous active-low reset; sampled on rising edge of clk
enqueue  in  1  write new entry at tail
i_vld  in  1  entry is committed on arrival
i_eip  in  EW  EIP of the store
i_addr  in  AW  store address
i_data  in  DW  store data
i_size  in  3  store size code
i_commit  in  1  commit request
i_commit_eip  in  EW  EIP to commit
i_flush  in  1  discard all uncommitted entries
read  in  1  cache/mem accepts the head entry
o_en_vld  out  1  head entry allocated and committed
o_en_addr/o_en_data/o_en_eip/o_en_size  out  AW/DW/EW/3  head entry fields
i_ld_addr  in  AW  load lookup address
i_ld_size  in  3  load size code
o_fwd_hit  out  1  youngest entry with matching address has equal size
o_fwd_partial  out  1  youngest entry with matching address has different size; load must stall
o_fwd_data  out  DW  data of that youngest matching entry
o_alloc  out  DEPTH  per-entry allocated bits
o_count  out  PW+1  occupied entries
empty  out  1  o_count==0
full  out  1  o_count==DEPTH
o_overflow  out  1  sticky: an enqueue was dropped

Behaviour:
- Reset (rst=0 at an edge):
  - all alloc and vld bits cleared; wrptr=rdptr=0; count=0; o_overflow=0;
  - all entry field registers cleared to 0.
  - So after reset: empty=1, full=0, o_en_vld=0, o_fwd_hit=0, o_fwd_partial=0, all head/forward data outputs 0.
  - Reset overrides every other input.
- Pointers wrap modulo DEPTH.
- Drain: drain = read & o_en_vld. On drain, the head entry's alloc and vld are cleared, rdptr advances, count decrements. read while o_en_vld=0 is ignored.
- Enqueue accept rule: accepted when !full, or when full and drain occurs in the same cycle.
  - Accepted: entry at wrptr is written with alloc=1, vld=i_vld, and all fields; wrptr advances; count increments.
  - Full with a simultaneous drain: the new entry overwrites the slot just freed; alloc stays 1; count is unchanged.
  - Otherwise the enqueue is dropped, state is unchanged, and o_overflow is set (sticky until reset).
- Commit: when i_commit=1, every allocated entry with eip==i_commit_eip gets vld=1.
  - If an enqueue in the same cycle carries i_eip==i_commit_eip, the new entry is written with vld=1 regardless of i_vld.
- Committed entries always form a contiguous prefix starting at the head. This is an upstream guarantee (commits arrive in program order); the bench must not violate it.
- Flush: i_flush clears alloc for every entry with vld=0, and sets wrptr = rdptr + (number of committed entries remaining after this cycle's drain).
  - Flush takes priority over enqueue in the same cycle: the enqueue is discarded and o_overflow is not set.
  - Drain and commit are evaluated first, so entries committed this cycle survive the flush.
- Combinational outputs:
  - o_en_* follow the entry at rdptr.
  - Lookup scans allocated entries with addr==i_ld_addr and selects the youngest, i.e. the largest (idx-rdptr) mod DEPTH.
    - Selected entry's size==i_ld_size: o_fwd_hit=1, o_fwd_data = its data.
    - Selected entry's size differs: o_fwd_partial=1, o_fwd_hit=0.
    - No matching entry: both flags 0 and o_fwd_data=0.
  - Uncommitted entries do forward.
- No latency beyond one clock for any state update; all outputs except o_overflow are combinational from state or inputs.

Test Plan:
- Reset, then enqueue addr 0x10..0x17 with i_vld=1 (DEPTH=8) -> full=1, o_count=8. A 9th enqueue with read=0 -> dropped, o_overflow=1, entry 0 addr still 0x10.
- Full buffer, enqueue addr 0x20 together with read=1 -> head 0x10 drained, slot 0 holds 0x20, o_count stays 8, o_en_addr=0x11. Wrap: keep draining -> 0x20 emerges after 0x17.
- Enqueue three entries eip=0x100 with i_vld=0, then i_commit with eip 0x100 -> o_en_vld goes 0 to 1 the next cycle. Also enqueue with i_eip=i_commit_eip in the same cycle -> that entry has vld=1.
- Enqueue eip A committed, then B and C uncommitted; i_flush -> o_count=1, wrptr=rdptr+1. Next enqueue lands right after A. Repeat with enqueue and flush in the same cycle -> enqueue discarded, o_overflow=0.
- Enqueue addr 0x40 data 0x1111 size 2, then addr 0x40 data 0x2222 size 2.
  - Lookup 0x40 size 2 -> o_fwd_hit=1, o_fwd_data=0x2222.
  - Lookup 0x40 size 1 -> o_fwd_partial=1.
  - Lookup 0x44 -> both flags 0.
- Mid-operation rst=0 with 5 entries, commit and read asserted in the same cycle -> next cycle empty=1, o_count=0, o_en_vld=0, o_overflow=0.

Source files
------------

// File: rtl/wb_buffer_param.sv
// Parametrised write-back store buffer.
// Circular FIFO of store entries between the WB pipeline latch and cache/mem.
// Entries are enqueued at the tail and committed by EIP. They drain in order
// from the head once committed. A flush discards speculative entries. Loads
// can look up the youngest matching store for forwarding.
module wb_buffer_param #(
    parameter int DEPTH = 8,
    parameter int AW    = 15,
    parameter int DW    = 32,
    parameter int EW    = 32,
    parameter int PW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enqueue,
    input  logic             i_vld,
    input  logic [EW-1:0]    i_eip,
    input  logic [AW-1:0]    i_addr,
    input  logic [DW-1:0]    i_data,
    input  logic [2:0]       i_size,
    input  logic             i_commit,
    input  logic [EW-1:0]    i_commit_eip,
    input  logic             i_flush,
    input  logic             read,
    output logic             o_en_vld,
    output logic [AW-1:0]    o_en_addr,
    output logic [DW-1:0]    o_en_data,
    output logic [EW-1:0]    o_en_eip,
    output logic [2:0]       o_en_size,
    input  logic [AW-1:0]    i_ld_addr,
    input  logic [2:0]       i_ld_size,
    output logic             o_fwd_hit,
    output logic             o_fwd_partial,
    output logic [DW-1:0]    o_fwd_data,
    output logic [DEPTH-1:0] o_alloc,
    output logic [PW:0]      o_count,
    output logic             empty,
    output logic             full,
    output logic             o_overflow
);

    logic [DEPTH-1:0] alloc_q, alloc_d;
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [EW-1:0]    eip_q  [DEPTH];
    logic [EW-1:0]    eip_d  [DEPTH];
    logic [AW-1:0]    addr_q [DEPTH];
    logic [AW-1:0]    addr_d [DEPTH];
    logic [DW-1:0]    data_q [DEPTH];
    logic [DW-1:0]    data_d [DEPTH];
    logic [2:0]       size_q [DEPTH];
    logic [2:0]       size_d [DEPTH];
    logic [PW-1:0]    wrptr_q, wrptr_d;
    logic [PW-1:0]    rdptr_q, rdptr_d;
    logic [PW:0]      count_q, count_d;
    logic             overflow_q, overflow_d;

    logic             drain;
    logic             accept;
    logic             drop;
    logic [PW:0]      ncommit;

    logic             fwd_found;
    logic [PW-1:0]    fwd_sel;
    logic [PW-1:0]    fwd_age;
    logic [PW-1:0]    fwd_best_age;

    // Head entry is presented to memory; it may leave only once committed
    assign o_en_vld  = alloc_q[rdptr_q] & vld_q[rdptr_q];
    assign o_en_addr = addr_q[rdptr_q];
    assign o_en_data = data_q[rdptr_q];
    assign o_en_eip  = eip_q[rdptr_q];
    assign o_en_size = size_q[rdptr_q];

    assign o_alloc    = alloc_q;
    assign o_count    = count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == (PW+1)'(DEPTH));
    assign o_overflow = overflow_q;

    assign drain  = read & o_en_vld;
    assign accept = enqueue & ~i_flush & (~full | drain);
    assign drop   = enqueue & ~i_flush & full & ~drain;

    // Next state: commit, then drain, then enqueue, then flush of speculative entries
    always_comb begin
        alloc_d    = alloc_q;
        vld_d      = vld_q;
        eip_d      = eip_q;
        addr_d     = addr_q;
        data_d     = data_q;
        size_d     = size_q;
        wrptr_d    = wrptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        ncommit    = '0;
        rdptr_d    = rdptr_q + PW'(drain);

        if (i_commit) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_q[i] && (eip_q[i] == i_commit_eip)) begin
                    vld_d[i] = 1'b1;
                end
            end
        end

        if (drain) begin
            alloc_d[rdptr_q] = 1'b0;
            vld_d[rdptr_q]   = 1'b0;
        end

        if (accept) begin
            alloc_d[wrptr_q] = 1'b1;
            vld_d[wrptr_q]   = i_vld | (i_commit & (i_eip == i_commit_eip));
            eip_d[wrptr_q]   = i_eip;
            addr_d[wrptr_q]  = i_addr;
            data_d[wrptr_q]  = i_data;
            size_d[wrptr_q]  = i_size;
            wrptr_d          = wrptr_q + 1'b1;
        end

        if (i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!vld_d[i]) begin
                    alloc_d[i] = 1'b0;
                end
                ncommit = ncommit + (PW+1)'(alloc_d[i] & vld_d[i]);
            end
            wrptr_d = rdptr_d + ncommit[PW-1:0];
            count_d = ncommit;
        end else begin
            count_d = count_q + (PW+1)'(accept) - (PW+1)'(drain);
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            alloc_q    <= '0;
            vld_q      <= '0;
            wrptr_q    <= '0;
            rdptr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                eip_q[i]  <= '0;
                addr_q[i] <= '0;
                data_q[i] <= '0;
                size_q[i] <= '0;
            end
        end else begin
            alloc_q    <= alloc_d;
            vld_q      <= vld_d;
            wrptr_q    <= wrptr_d;
            rdptr_q    <= rdptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            for (int i = 0; i < DEPTH; i++) begin
                eip_q[i]  <= eip_d[i];
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
                size_q[i] <= size_d[i];
            end
        end
    end

    // Load lookup: youngest allocated entry with matching address, age measured from head
    always_comb begin
        fwd_found    = 1'b0;
        fwd_sel      = '0;
        fwd_age      = '0;
        fwd_best_age = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_age = PW'(i) - rdptr_q;
            if (alloc_q[i] && (addr_q[i] == i_ld_addr) &&
                (!fwd_found || (fwd_age > fwd_best_age))) begin
                fwd_found    = 1'b1;
                fwd_sel      = PW'(i);
                fwd_best_age = fwd_age;
            end
        end
        o_fwd_hit     = fwd_found & (size_q[fwd_sel] == i_ld_size);
        o_fwd_partial = fwd_found & (size_q[fwd_sel] != i_ld_size);
        o_fwd_data    = fwd_found ? data_q[fwd_sel] : '0;
    end

endmodule
